// File: rtl/ysyx_22040175_pipe_pkg.sv
// rtl/ysyx_22040175_pipe_pkg.sv - shared pipeline tracker types and stage indices
//
// Contents:
//   TRACK_RD_W    - stored rd width; REG_ADDR_WIDTH up to 8 is zero-extended into it
//   STG_EX/STG_MEM - tracker stage indices shared with the stage registers
//   FWD_RF        - forward select value meaning "read the register file"
//   track_entry_t - one in-flight producer {valid, rd, wen, is_load}
package ysyx_22040175_pipe_pkg;

    localparam int TRACK_RD_W = 8;

    localparam int STG_EX  = 1;
    localparam int STG_MEM = 2;

    localparam int FWD_RF = 0;

    typedef struct packed {
        logic                  valid;
        logic [TRACK_RD_W-1:0] rd;
        logic                  wen;
        logic                  is_load;
    } track_entry_t;

endpackage

// File: rtl/ysyx_22040175_hazard_ctrl_if.sv
// rtl/ysyx_22040175_hazard_ctrl_if.sv - ID-stage operand info in, hazard controls out
//
// master: pipeline side, drives ID info and ex_redirect, receives controls
// slave : hazard controller side
interface ysyx_22040175_hazard_ctrl_if #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int NUM_STAGES     = 3,
    parameter int FWD_W          = $clog2(NUM_STAGES + 1)
);
    logic                      id_valid;
    logic [REG_ADDR_WIDTH-1:0] id_rs1;
    logic [REG_ADDR_WIDTH-1:0] id_rs2;
    logic                      id_rs1_used;
    logic                      id_rs2_used;
    logic [REG_ADDR_WIDTH-1:0] id_rd;
    logic                      id_wen;
    logic                      id_is_load;
    logic                      ex_redirect;
    logic                      stall_if_id;
    logic                      bubble_id_ex;
    logic                      flush_if_id;
    logic [FWD_W-1:0]          fwd_sel1;
    logic [FWD_W-1:0]          fwd_sel2;
    logic [31:0]               stall_cnt;

    modport master (
        output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
               id_rd, id_wen, id_is_load, ex_redirect,
        input  stall_if_id, bubble_id_ex, flush_if_id, fwd_sel1, fwd_sel2, stall_cnt
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
               id_rd, id_wen, id_is_load, ex_redirect,
        output stall_if_id, bubble_id_ex, flush_if_id, fwd_sel1, fwd_sel2, stall_cnt
    );
endinterface

// File: rtl/ysyx_22040175_hazard_match.sv
// rtl/ysyx_22040175_hazard_match.sv - per-operand tracker match and priority encoder
//
// Inputs : trk (tracker entries 1..NUM_STAGES), rs, rs_used, id_valid
// Outputs: match, win_idx (youngest matching stage), load_not_ready
module ysyx_22040175_hazard_match
    import ysyx_22040175_pipe_pkg::*;
#(
    parameter int REG_ADDR_WIDTH   = 5,
    parameter int NUM_STAGES       = 3,
    parameter int LOAD_READY_STAGE = STG_MEM,
    parameter int FWD_W            = $clog2(NUM_STAGES + 1)
) (
    input  track_entry_t [NUM_STAGES:1] trk,
    input  logic [REG_ADDR_WIDTH-1:0]   rs,
    input  logic                        rs_used,
    input  logic                        id_valid,
    output logic                        match,
    output logic [FWD_W-1:0]            win_idx,
    output logic                        load_not_ready
);

    logic [TRACK_RD_W-1:0] rs_ext;
    logic                  win_load;

    assign rs_ext = TRACK_RD_W'(rs);

    // Scan oldest to youngest so the lowest matching stage overwrites the rest.
    always_comb begin
        match    = 1'b0;
        win_idx  = '0;
        win_load = 1'b0;
        for (int k = NUM_STAGES; k >= 1; k--) begin
            if (id_valid && rs_used && trk[k].valid && trk[k].wen &&
                (trk[k].rd != '0) && (trk[k].rd == rs_ext)) begin
                match    = 1'b1;
                win_idx  = FWD_W'(k);
                win_load = trk[k].is_load;
            end
        end
    end

    assign load_not_ready = match && win_load && (int'(win_idx) < LOAD_READY_STAGE);

endmodule

// File: rtl/ysyx_22040175_hazard_ctrl.sv
// rtl/ysyx_22040175_hazard_ctrl.sv - pipeline hazard, stall and forwarding controller
//
// Ports: clk, rst (async, active high), hz (ysyx_22040175_hazard_ctrl_if.slave)
// Macro YSYX_22040175_FWD_EN: defined -> forwarding with load-use stalls;
// undefined -> forward selects tied to 0, any match interlocks until the
// producer leaves the tracker.
module ysyx_22040175_hazard_ctrl
    import ysyx_22040175_pipe_pkg::*;
#(
    parameter int REG_ADDR_WIDTH   = 5,
    parameter int NUM_STAGES       = 3,
    parameter int LOAD_READY_STAGE = STG_MEM,
    parameter int FWD_W            = $clog2(NUM_STAGES + 1)
) (
    input logic                       clk,
    input logic                       rst,
    ysyx_22040175_hazard_ctrl_if.slave hz
);

    track_entry_t [NUM_STAGES:1] trk;
    track_entry_t                new_entry;

    logic             match1, match2;
    logic             lnr1, lnr2;
    logic [FWD_W-1:0] idx1, idx2;
    logic             data_hazard;
    logic             bubble;
    logic [31:0]      stall_cnt_q;

    ysyx_22040175_hazard_match #(
        .REG_ADDR_WIDTH  (REG_ADDR_WIDTH),
        .NUM_STAGES      (NUM_STAGES),
        .LOAD_READY_STAGE(LOAD_READY_STAGE),
        .FWD_W           (FWD_W)
    ) u_match_rs1 (
        .trk           (trk),
        .rs            (hz.id_rs1),
        .rs_used       (hz.id_rs1_used),
        .id_valid      (hz.id_valid),
        .match         (match1),
        .win_idx       (idx1),
        .load_not_ready(lnr1)
    );

    ysyx_22040175_hazard_match #(
        .REG_ADDR_WIDTH  (REG_ADDR_WIDTH),
        .NUM_STAGES      (NUM_STAGES),
        .LOAD_READY_STAGE(LOAD_READY_STAGE),
        .FWD_W           (FWD_W)
    ) u_match_rs2 (
        .trk           (trk),
        .rs            (hz.id_rs2),
        .rs_used       (hz.id_rs2_used),
        .id_valid      (hz.id_valid),
        .match         (match2),
        .win_idx       (idx2),
        .load_not_ready(lnr2)
    );

`ifdef YSYX_22040175_FWD_EN
    assign data_hazard = lnr1 | lnr2;
    // A load that is not ready yet must not be forwarded from a stale stage.
    assign hz.fwd_sel1 = (match1 && !lnr1) ? idx1 : FWD_W'(FWD_RF);
    assign hz.fwd_sel2 = (match2 && !lnr2) ? idx2 : FWD_W'(FWD_RF);
`else
    logic unused_fwd;
    assign unused_fwd  = ^{idx1, idx2, lnr1, lnr2};
    assign data_hazard = match1 | match2;
    assign hz.fwd_sel1 = FWD_W'(FWD_RF);
    assign hz.fwd_sel2 = FWD_W'(FWD_RF);
`endif

    // The redirect squashes the ID instruction, so holding IF/ID would be wrong.
    assign bubble          = data_hazard | hz.ex_redirect;
    assign hz.stall_if_id  = data_hazard & ~hz.ex_redirect;
    assign hz.bubble_id_ex = bubble;
    assign hz.flush_if_id  = hz.ex_redirect;
    assign hz.stall_cnt    = stall_cnt_q;

    always_comb begin
        new_entry = '0;
        if (hz.id_valid && !bubble) begin
            new_entry.valid   = 1'b1;
            new_entry.rd      = TRACK_RD_W'(hz.id_rd);
            new_entry.wen     = hz.id_wen;
            new_entry.is_load = hz.id_is_load;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trk <= '0;
        end else begin
            for (int k = NUM_STAGES; k >= 2; k--) begin
                trk[k] <= trk[k-1];
            end
            trk[STG_EX] <= new_entry;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else if (hz.stall_if_id) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

endmodule

// File: tb/tb_ysyx_22040175_hazard_ctrl.sv
// tb/tb_ysyx_22040175_hazard_ctrl.sv - table-driven bench for the hazard controller
module tb_ysyx_22040175_hazard_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    ysyx_22040175_hazard_ctrl_if hz ();

    ysyx_22040175_hazard_ctrl dut (
        .clk(clk),
        .rst(rst),
        .hz (hz.slave)
    );

    typedef struct {
        logic       v;
        logic [4:0] rs1;
        logic       u1;
        logic [4:0] rs2;
        logic       u2;
        logic [4:0] rd;
        logic       wen;
        logic       ld;
        logic       redir;
        logic       e_stall;
        logic       e_bub;
        logic       e_flush;
        int         e_f1;
        int         e_f2;
        int         e_cnt;
    } vec_t;

    vec_t tbl[$];
    int   checks   = 0;
    int   failures = 0;

`ifdef YSYX_22040175_FWD_EN
    localparam int CNT_PRE = 1;
`else
    localparam int CNT_PRE = 7;
`endif

    function automatic vec_t mk(input logic v, input int rs1, input logic u1,
                                input int rs2, input logic u2, input int rd,
                                input logic wen, input logic ld, input logic redir,
                                input logic es, input logic eb, input logic ef,
                                input int f1, input int f2, input int cnt);
        vec_t r;
        r.v = v; r.rs1 = 5'(rs1); r.u1 = u1; r.rs2 = 5'(rs2); r.u2 = u2;
        r.rd = 5'(rd); r.wen = wen; r.ld = ld; r.redir = redir;
        r.e_stall = es; r.e_bub = eb; r.e_flush = ef;
        r.e_f1 = f1; r.e_f2 = f2; r.e_cnt = cnt;
        return r;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input int rs1, input logic u1, input int rs2,
                         input logic u2, input int rd, input logic wen, input logic ld,
                         input logic redir);
        hz.id_valid    = v;
        hz.id_rs1      = 5'(rs1);
        hz.id_rs1_used = u1;
        hz.id_rs2      = 5'(rs2);
        hz.id_rs2_used = u2;
        hz.id_rd       = 5'(rd);
        hz.id_wen      = wen;
        hz.id_is_load  = ld;
        hz.ex_redirect = redir;
    endtask

    task automatic chk_all(input string tag, input logic es, input logic eb, input logic ef,
                           input int f1, input int f2, input int cnt);
        chk({tag, ".stall"},  int'(hz.stall_if_id),  int'(es));
        chk({tag, ".bubble"}, int'(hz.bubble_id_ex), int'(eb));
        chk({tag, ".flush"},  int'(hz.flush_if_id),  int'(ef));
        chk({tag, ".fwd1"},   int'(hz.fwd_sel1),     f1);
        chk({tag, ".fwd2"},   int'(hz.fwd_sel2),     f2);
        chk({tag, ".cnt"},    int'(hz.stall_cnt),    cnt);
    endtask

    initial begin
`ifdef YSYX_22040175_FWD_EN
        //               v rs1 u1 rs2 u2 rd wen ld rdr | st bb fl f1 f2 cnt
        tbl.push_back(mk(1,  1, 1,  2, 1,  5, 1, 0, 0,   0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1,  5, 1,  3, 1,  8, 1, 0, 0,   0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(1,  9, 1,  5, 1, 10, 1, 0, 0,   0, 0, 0, 0, 2, 0));
        tbl.push_back(mk(1,  5, 1,  0, 1, 11, 1, 0, 0,   0, 0, 0, 3, 0, 0));
        tbl.push_back(mk(0, 11, 1,  0, 0,  0, 0, 0, 0,   0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 11, 1,  0, 0,  6, 1, 1, 0,   0, 0, 0, 2, 0, 0));
        tbl.push_back(mk(1,  6, 1,  6, 1, 12, 1, 0, 0,   1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1,  6, 1,  6, 1, 12, 1, 0, 0,   0, 0, 0, 2, 2, 1));
        tbl.push_back(mk(1, 12, 0,  6, 1,  0, 1, 0, 0,   0, 0, 0, 0, 3, 1));
        tbl.push_back(mk(1,  0, 1, 12, 0, 13, 1, 0, 0,   0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(1,  0, 0,  0, 0,  7, 1, 0, 0,   0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(1, 13, 1,  0, 0, 15, 1, 0, 0,   0, 0, 0, 2, 0, 1));
        tbl.push_back(mk(1,  0, 0,  0, 0,  7, 1, 0, 0,   0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(1,  7, 1, 15, 1, 16, 1, 0, 0,   0, 0, 0, 1, 2, 1));
        tbl.push_back(mk(1, 15, 1,  0, 0,  0, 0, 0, 0,   0, 0, 0, 3, 0, 1));
        tbl.push_back(mk(1,  0, 0,  0, 0, 20, 1, 1, 0,   0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(1, 20, 1,  0, 0, 21, 1, 0, 1,   0, 1, 1, 0, 0, 1));
        tbl.push_back(mk(1, 21, 1, 20, 1,  0, 0, 0, 0,   0, 0, 0, 0, 2, 1));
`else
        tbl.push_back(mk(1,  1, 1,  2, 1,  5, 1, 0, 0,   0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1,  5, 1,  3, 1,  8, 1, 0, 0,   1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1,  5, 1,  3, 1,  8, 1, 0, 0,   1, 1, 0, 0, 0, 1));
        tbl.push_back(mk(1,  5, 1,  3, 1,  8, 1, 0, 0,   1, 1, 0, 0, 0, 2));
        tbl.push_back(mk(1,  5, 1,  3, 1,  8, 1, 0, 0,   0, 0, 0, 0, 0, 3));
        tbl.push_back(mk(1,  0, 1,  0, 0,  6, 1, 1, 0,   0, 0, 0, 0, 0, 3));
        tbl.push_back(mk(1,  6, 1,  7, 0, 12, 1, 0, 0,   1, 1, 0, 0, 0, 3));
        tbl.push_back(mk(1,  6, 1,  7, 0, 12, 1, 0, 0,   1, 1, 0, 0, 0, 4));
        tbl.push_back(mk(1,  6, 1,  7, 0, 12, 1, 0, 0,   1, 1, 0, 0, 0, 5));
        tbl.push_back(mk(1,  6, 1,  7, 0, 12, 1, 0, 0,   0, 0, 0, 0, 0, 6));
        tbl.push_back(mk(1, 12, 0,  0, 1,  0, 1, 0, 0,   0, 0, 0, 0, 0, 6));
        tbl.push_back(mk(1,  0, 1, 12, 0, 13, 1, 0, 0,   0, 0, 0, 0, 0, 6));
        tbl.push_back(mk(1, 13, 1,  0, 0, 21, 1, 0, 1,   0, 1, 1, 0, 0, 6));
        tbl.push_back(mk(1, 21, 1, 13, 1,  0, 0, 0, 0,   1, 1, 0, 0, 0, 6));
        tbl.push_back(mk(0,  0, 0, 13, 1,  0, 0, 0, 0,   0, 0, 0, 0, 0, 7));
`endif

        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1 rst = 1'b1;
        #1 chk_all("reset", 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;

        foreach (tbl[i]) begin
            @(negedge clk);
            drive(tbl[i].v, tbl[i].rs1, tbl[i].u1, tbl[i].rs2, tbl[i].u2,
                  tbl[i].rd, tbl[i].wen, tbl[i].ld, tbl[i].redir);
            #1;
            chk_all($sformatf("row%0d", i), tbl[i].e_stall, tbl[i].e_bub, tbl[i].e_flush,
                    tbl[i].e_f1, tbl[i].e_f2, tbl[i].e_cnt);
        end

        // Asynchronous reset in the middle of a load-use stall.
        @(negedge clk);
        drive(1, 0, 0, 0, 0, 6, 1, 1, 0);
        #1 chk("pre_lw.stall", int'(hz.stall_if_id), 0);
        @(negedge clk);
        drive(1, 6, 1, 0, 0, 9, 1, 0, 0);
        #1 chk("lu.stall", int'(hz.stall_if_id), 1);
        chk("lu.cnt", int'(hz.stall_cnt), CNT_PRE);
        #1 rst = 1'b1;
        #1 chk_all("async_rst", 0, 0, 0, 0, 0, 0);
        drive(0, 6, 1, 0, 0, 9, 1, 0, 0);
        #1 chk_all("async_rst_idle", 0, 0, 0, 0, 0, 0);
        @(posedge clk);

        // First edge after release loads the tracker again.
        @(negedge clk);
        rst = 1'b0;
        drive(1, 0, 0, 0, 0, 6, 1, 1, 0);
        #1 chk("post_rst_lw.stall", int'(hz.stall_if_id), 0);
        @(negedge clk);
        drive(1, 6, 1, 0, 0, 9, 1, 0, 0);
        #1 chk_all("post_rst_lu", 1, 1, 0, 0, 0, 0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1 chk("post_rst_cnt", int'(hz.stall_cnt), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
